sync_f2s_arb: RTL and testbench

- Fast-domain controller that shares one fast-to-slow shake-hands channel among N_REQ requesters.
- Grants requesters round-robin and sequences the 4-phase request/ack protocol: raise request, wait for ack high, drop request, wait for ack low.
- Drives a clock-enable low while a transfer is in flight. This implements the "stop the fast clock" method for the downstream fast logic.
- Includes an ack-timeout abort so a dead slow domain cannot hang the fast side.

---
 rtl/sync_f2s_pkg.sv | 16 +
 rtl/sync_f2s_ack_sync.sv | 26 ++
 rtl/sync_f2s_arb.sv | 150 +++++++++++++++
 tb/tb_sync_f2s_arb.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_f2s_pkg.sv
// Shared types and defaults for the fast-to-slow arbitrated handshake.
// Imported by the arbiter and its ack synchronizer.
package sync_f2s_pkg;

  typedef enum logic [2:0] {
    ST_RECOV,
    ST_IDLE,
    ST_REQ,
    ST_REL,
    ST_ABORT
  } state_e;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TIMEOUT     = 255;

endpackage

// File: rtl/sync_f2s_ack_sync.sv
// Multi-flop synchronizer for the slow-domain ack.
// Resets high so an ack left over from before reset is always drained.
module sync_f2s_ack_sync
  import sync_f2s_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/sync_f2s_arb.sv
// Round-robin owner of one fast-to-slow 4-phase handshake channel.
// Holds the downstream clock enable low for the whole transfer.
module sync_f2s_arb
  import sync_f2s_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int CNT_W       = 8
) (
  input  logic             clk_f,
  input  logic             rst_f,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [N_REQ-1:0] done_o,
  output logic             err_o,
  output logic             busy_o,
  output logic             clk_en_o,
  output logic             xfer_req_o,
  input  logic             xfer_ack_i
);

  localparam int PW = $clog2(N_REQ);
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e           state_q;
  logic [PW-1:0]    ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N_REQ-1:0] gnt_q;
  logic [N_REQ-1:0] done_q;
  logic             err_q;
  logic             xreq_q;
  logic             busy_q;
  logic             clk_en_q;

  logic             ack_s;
  logic [PW-1:0]    win_d;
  logic [PW-1:0]    ptr_d;

  sync_f2s_ack_sync #(
    .STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk_i(clk_f),
    .rst_i(rst_f),
    .d_i  (xfer_ack_i),
    .q_o  (ack_s)
  );

  // First set bit at or above p, wrapping past N_REQ-1 to 0.
  function automatic logic [PW-1:0] rr_pick(
    input logic [N_REQ-1:0] r,
    input logic [PW-1:0]    p
  );
    logic [PW-1:0] w;
    logic [PW-1:0] idx;
    logic          hit;
    w   = '0;
    hit = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = PW'((int'(p) + i) % N_REQ);
      if (!hit && r[idx]) begin
        w   = idx;
        hit = 1'b1;
      end
    end
    return w;
  endfunction

  always_comb begin
    win_d = rr_pick(req_i, ptr_q);
    ptr_d = (win_d == PW'(N_REQ - 1)) ? '0 : win_d + 1'b1;
  end

  always_ff @(posedge clk_f) begin
    if (rst_f) begin
      state_q  <= ST_RECOV;
      ptr_q    <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
      xreq_q   <= 1'b0;
      busy_q   <= 1'b1;
      clk_en_q <= 1'b1;
    end else begin
      done_q <= '0;
      err_q  <= 1'b0;
      unique case (state_q)
        ST_RECOV: begin
          xreq_q <= 1'b0;
          if (!ack_s) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (|req_i) begin
            gnt_q    <= N_REQ'(1) << win_d;
            ptr_q    <= ptr_d;
            cnt_q    <= '0;
            xreq_q   <= 1'b1;
            busy_q   <= 1'b1;
            clk_en_q <= 1'b0;
            state_q  <= ST_REQ;
          end
        end
        ST_REQ: begin
          cnt_q <= cnt_q + 1'b1;
          // Ack wins over a timeout landing on the same cycle.
          if (ack_s) begin
            xreq_q  <= 1'b0;
            state_q <= ST_REL;
          end else if (TO_EN && cnt_q == TO_LAST) begin
            xreq_q  <= 1'b0;
            err_q   <= 1'b1;
            gnt_q   <= '0;
            state_q <= ST_ABORT;
          end
        end
        ST_REL: begin
          if (!ack_s) begin
            done_q   <= gnt_q;
            gnt_q    <= '0;
            busy_q   <= 1'b0;
            clk_en_q <= 1'b1;
            state_q  <= ST_IDLE;
          end
        end
        ST_ABORT: begin
          if (!ack_s) begin
            busy_q   <= 1'b0;
            clk_en_q <= 1'b1;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_RECOV;
      endcase
    end
  end

  assign gnt_o      = gnt_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign busy_o     = busy_q;
  assign clk_en_o   = clk_en_q;
  assign xfer_req_o = xreq_q;

endmodule

// File: tb/tb_sync_f2s_arb.sv
// Bench for sync_f2s_arb: directed scenarios plus random traffic,
// all outputs compared each cycle against a transfer-level model.
module tb_sync_f2s_arb;

  localparam int N  = 4;
  localparam int S  = 2;
  localparam int TO = 8;
  localparam int CW = 8;

  logic         clk_f = 1'b0;
  logic         rst_f = 1'b1;
  logic [N-1:0] req_i = '0;
  logic [N-1:0] gnt_o;
  logic [N-1:0] done_o;
  logic         err_o;
  logic         busy_o;
  logic         clk_en_o;
  logic         xfer_req_o;
  logic         xfer_ack_i = 1'b0;

  always #5 clk_f = ~clk_f;

  sync_f2s_arb #(
    .N_REQ(N), .SYNC_STAGES(S), .TIMEOUT(TO), .CNT_W(CW)
  ) dut (
    .clk_f(clk_f), .rst_f(rst_f), .req_i(req_i),
    .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o),
    .busy_o(busy_o), .clk_en_o(clk_en_o),
    .xfer_req_o(xfer_req_o), .xfer_ack_i(xfer_ack_i)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 0;

  // Slow-domain responder, delays in fast cycles.
  int d_up = 2, d_dn = 2;
  bit dead = 0, hold_hi = 0;
  int up_c = 0, dn_c = 0;

  always @(negedge clk_f) begin
    if (hold_hi) begin
      xfer_ack_i = 1'b1;
    end else if (xfer_req_o === 1'b1) begin
      dn_c = 0;
      up_c++;
      if (!dead && up_c >= d_up) xfer_ack_i = 1'b1;
    end else begin
      up_c = 0;
      if (xfer_ack_i) begin
        dn_c++;
        if (dn_c >= d_dn) begin
          xfer_ack_i = 1'b0;
          dn_c = 0;
        end
      end
    end
  end

  // Reference model: transfer phases, ack seen through an S-deep delay line.
  typedef enum {P_DRAIN, P_IDLE, P_WAIT, P_REL, P_ABORT} phase_e;
  phase_e       ph = P_DRAIN;
  logic [N-1:0] e_gnt = '0, e_done = '0;
  logic         e_err = 1'b0, e_xreq = 1'b0;
  int           nxt = 0, waited = 0;
  bit           line[$];

  always @(posedge clk_f) begin
    bit acks;
    int w;
    acks = (line.size() > 0) ? line[0] : 1'b1;
    e_done = '0;
    e_err  = 1'b0;
    if (rst_f) begin
      ph = P_DRAIN; e_gnt = '0; e_xreq = 1'b0; nxt = 0; waited = 0;
      line = {};
      for (int i = 0; i < S; i++) line.push_back(1'b1);
    end else begin
      case (ph)
        P_DRAIN: if (!acks) ph = P_IDLE;
        P_IDLE: if (req_i != 0) begin
          w = -1;
          for (int k = 0; k < N; k++)
            if (w < 0 && req_i[(nxt + k) % N]) w = (nxt + k) % N;
          e_gnt = '0;
          e_gnt[w] = 1'b1;
          e_xreq = 1'b1;
          nxt = (w + 1) % N;
          waited = 0;
          ph = P_WAIT;
        end
        P_WAIT: begin
          waited++;
          if (acks) begin
            e_xreq = 1'b0; ph = P_REL;
          end else if (TO != 0 && waited == TO) begin
            e_xreq = 1'b0; e_err = 1'b1; e_gnt = '0; ph = P_ABORT;
          end
        end
        P_REL: if (!acks) begin
          e_done = e_gnt; e_gnt = '0; ph = P_IDLE;
        end
        P_ABORT: if (!acks) ph = P_IDLE;
        default: ph = P_DRAIN;
      endcase
      if (line.size() > 0) begin
        line.push_back(xfer_ack_i);
        void'(line.pop_front());
      end
    end
  end

  always @(negedge clk_f) begin
    logic e_busy, e_ce;
    if (chk_on) begin
      e_busy = (ph != P_IDLE);
      e_ce   = (ph == P_DRAIN || ph == P_IDLE);
      n_tests++;
      if ({gnt_o, done_o, err_o, xfer_req_o, busy_o, clk_en_o} !==
          {e_gnt, e_done, e_err, e_xreq, e_busy, e_ce}) begin
        n_fail++;
        $display("FAIL cycle_model @%0t: got gnt=%b done=%b err=%b req=%b busy=%b ce=%b, want gnt=%b done=%b err=%b req=%b busy=%b ce=%b",
          $time, gnt_o, done_o, err_o, xfer_req_o, busy_o, clk_en_o,
          e_gnt, e_done, e_err, e_xreq, e_busy, e_ce);
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic wait_idle(input string nm);
    int t = 0;
    while (busy_o !== 1'b0 && t < 200) begin
      @(negedge clk_f); t++;
    end
    if (busy_o !== 1'b0) chk({nm, "_idle_timeout"}, t, -1);
  endtask

  // Waits for a grant, then for its done or err; returns at that cycle.
  task automatic wait_xfer(
    input  string        nm,
    input  bit           set_after,
    input  logic [N-1:0] after_req,
    output int           idx,
    output int           gwait,
    output int           lat,
    output bit           was_err
  );
    gwait = 0;
    lat = 0;
    idx = -1;
    was_err = 0;
    while (gnt_o == '0 && gwait < 200) begin
      @(negedge clk_f); gwait++;
    end
    if (gnt_o == '0) begin
      chk({nm, "_grant_timeout"}, gwait, -1);
      return;
    end
    idx = oh_idx(gnt_o);
    if (set_after) req_i = after_req;
    while (done_o == '0 && err_o !== 1'b1 && lat < 200) begin
      @(negedge clk_f); lat++;
    end
    if (done_o == '0 && err_o !== 1'b1) chk({nm, "_end_timeout"}, lat, -1);
    was_err = (err_o === 1'b1);
  endtask

  task automatic do_reset(input int n);
    rst_f = 1'b1;
    repeat (n) @(negedge clk_f);
    rst_f = 1'b0;
  endtask

  initial begin
    int idx, gw, lat, t, ce_low, xr_hi;
    bit er;
    int rr_exp[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    // Reset state and single-requester transfer.
    rst_f = 1'b1;
    @(negedge clk_f);
    chk_on = 1;
    chk("rst_gnt", int'(gnt_o), 0);
    chk("rst_busy", int'(busy_o), 1);
    chk("rst_clken", int'(clk_en_o), 1);
    chk("rst_xreq", int'(xfer_req_o), 0);
    @(negedge clk_f);
    rst_f = 1'b0;
    req_i = 4'b0100;
    t = 0;
    while (gnt_o == '0 && t < 50) begin
      @(negedge clk_f); t++;
    end
    chk("single_gnt", int'(gnt_o), 4);
    chk("single_grant_wait", t, 4);
    req_i = '0;
    ce_low = 0; xr_hi = 0; t = 0;
    while (done_o == '0 && t < 100) begin
      if (!clk_en_o) ce_low++;
      if (xfer_req_o) xr_hi++;
      @(negedge clk_f); t++;
    end
    chk("single_done", int'(done_o), 4);
    chk("single_latency", t, 8);
    chk("single_clken_low", ce_low, 8);
    chk("single_xreq_high", xr_hi, 4);
    chk("single_clken_at_done", int'(clk_en_o), 1);

    // Round-robin from a fresh pointer, then wrap after bit 3.
    d_up = 3; d_dn = 1;
    req_i = 4'b1111;
    do_reset(2);
    for (int i = 0; i < 8; i++) begin
      wait_xfer("rr", i == 7, 4'b1001, idx, gw, lat, er);
      chk($sformatf("rr_order_%0d", i), idx, rr_exp[i]);
      if (i > 0) chk($sformatf("rr_gap_%0d", i), gw, 1);
    end
    wait_xfer("wrap0", 0, '0, idx, gw, lat, er);
    chk("wrap_first", idx, 0);
    wait_xfer("wrap1", 1, '0, idx, gw, lat, er);
    chk("wrap_second", idx, 3);
    wait_idle("wrap");

    // Dead slow side: abort after TO cycles in REQ.
    d_up = 2; d_dn = 2; dead = 1;
    req_i = 4'b0001;
    wait_xfer("tmo", 1, '0, idx, gw, lat, er);
    chk("tmo_err", int'(er), 1);
    chk("tmo_latency", lat, 8);
    @(negedge clk_f);
    chk("tmo_clken", int'(clk_en_o), 1);
    chk("tmo_busy", int'(busy_o), 0);
    dead = 0;

    // Ack arriving on the last counted cycle beats the timeout.
    d_up = 6;
    req_i = 4'b0010;
    wait_xfer("ackto", 1, '0, idx, gw, lat, er);
    chk("ackto_err", int'(er), 0);
    chk("ackto_done", int'(done_o), 2);
    chk("ackto_latency", lat, 12);
    d_up = 7;
    req_i = 4'b0010;
    wait_xfer("late", 1, '0, idx, gw, lat, er);
    chk("late_err", int'(er), 1);
    chk("late_latency", lat, 8);
    wait_idle("late");

    // Reset while in REL with ack held high.
    d_up = 2; d_dn = 2;
    req_i = 4'b0100;
    t = 0;
    while (!(gnt_o != '0 && xfer_req_o === 1'b0) && t < 100) begin
      @(negedge clk_f); t++;
    end
    chk("midrst_reached_rel", int'(gnt_o), 4);
    hold_hi = 1;
    req_i = 4'b1111;
    do_reset(2);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("midrst_hold_%0d", i),
          int'({busy_o, clk_en_o, gnt_o}), 6'b110000);
      @(negedge clk_f);
    end
    hold_hi = 0;
    wait_xfer("midrst", 1, '0, idx, gw, lat, er);
    chk("midrst_regrant", idx, 0);
    wait_idle("midrst");

    // Random traffic, responder timing and occasional resets.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) req_i = N'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        d_up = $urandom_range(1, 8);
        d_dn = $urandom_range(1, 4);
        dead = ($urandom_range(0, 7) == 0);
      end
      rst_f = ($urandom_range(0, 199) == 0);
      @(negedge clk_f);
    end
    rst_f = 1'b0;
    req_i = '0;
    dead = 0;
    repeat (40) @(negedge clk_f);
    chk_on = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
